// File: rtl/ctrl_pkg.sv
// Shared constants for the registered ID-stage control sequencer: mode and
// opcode encodings, ALU command codes and the sequencer FSM state type.
package ctrl_pkg;

  localparam logic [1:0] MODE_DP  = 2'd0;
  localparam logic [1:0] MODE_MEM = 2'd1;
  localparam logic [1:0] MODE_BR  = 2'd2;
  localparam logic [1:0] MODE_BLK = 2'd3;

  localparam logic [3:0] OP_MOV  = 4'b1101;
  localparam logic [3:0] OP_MVN  = 4'b1111;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_ADC  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SBC  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ORR  = 4'b1100;
  localparam logic [3:0] OP_EOR  = 4'b0001;
  localparam logic [3:0] OP_CMP  = 4'b1010;
  localparam logic [3:0] OP_TST  = 4'b1000;
  localparam logic [3:0] OP_LDST = 4'b0100;

  localparam logic [3:0] EXE_NONE = 4'b0000;
  localparam logic [3:0] EXE_MOV  = 4'b0001;
  localparam logic [3:0] EXE_ADD  = 4'b0010;
  localparam logic [3:0] EXE_ADC  = 4'b0011;
  localparam logic [3:0] EXE_SUB  = 4'b0100;
  localparam logic [3:0] EXE_SBC  = 4'b0101;
  localparam logic [3:0] EXE_AND  = 4'b0110;
  localparam logic [3:0] EXE_ORR  = 4'b0111;
  localparam logic [3:0] EXE_EOR  = 4'b1000;
  localparam logic [3:0] EXE_MVN  = 4'b1001;

  typedef enum logic {ST_IDLE, ST_BLOCK} seq_state_t;

  // ALU command for the write-back data-processing opcodes; others map to 0.
  function automatic logic [3:0] dp_cmd(input logic [3:0] op);
    logic [3:0] cmd;
    cmd = EXE_NONE;
    case (op)
      OP_MOV: cmd = EXE_MOV;
      OP_MVN: cmd = EXE_MVN;
      OP_ADD: cmd = EXE_ADD;
      OP_ADC: cmd = EXE_ADC;
      OP_SUB: cmd = EXE_SUB;
      OP_SBC: cmd = EXE_SBC;
      OP_AND: cmd = EXE_AND;
      OP_ORR: cmd = EXE_ORR;
      OP_EOR: cmd = EXE_EOR;
      default: cmd = EXE_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of a vector plus an any-set flag.
module lowest_set_bit #(
  parameter int REG_COUNT = 16,
  parameter int IDX_W     = $clog2(REG_COUNT)
) (
  input  logic [REG_COUNT-1:0] vec,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  always_comb begin
    idx = '0;
    for (int unsigned i = REG_COUNT; i > 0; i--) begin
      if (vec[i-1]) idx = IDX_W'(i - 1);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/ctrl_sequencer.sv
// Registered ID-stage control decoder with stall/flush and LDM/STM expansion
// into one memory micro-op per set register-list bit.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int REG_COUNT = 16,
  parameter int REG_IDX_W = 4,
  parameter int OFFSET_W  = 6,
  parameter int EXE_CMD_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [3:0]           opcode,
  input  logic                 s_bit,
  input  logic                 nop,
  input  logic [REG_COUNT-1:0] reg_list,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 valid_out,
  output logic [EXE_CMD_W-1:0] exe_cmd,
  output logic                 wb_en,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 branch,
  output logic                 status_update,
  output logic [REG_IDX_W-1:0] uop_reg,
  output logic [OFFSET_W-1:0]  uop_offset,
  output logic                 uop_last
);

  seq_state_t           state, state_d;
  logic [REG_COUNT-1:0] pending, pending_d;
  logic [REG_IDX_W-1:0] ord, ord_d;
  logic                 blk_load, blk_load_d;

  logic [REG_COUNT-1:0] sel_list, rest;
  logic [REG_IDX_W-1:0] lsb_idx;
  logic                 lsb_any;
  logic                 accept, is_blk;

  logic                 valid_d, wb_d, rd_d, wr_d, br_d, su_d, last_d;
  logic [EXE_CMD_W-1:0] exe_d;
  logic [REG_IDX_W-1:0] reg_d;
  logic [OFFSET_W-1:0]  off_d;

  assign in_ready = (state == ST_IDLE) && !stall;
  assign accept   = valid_in && in_ready && !flush;
  assign is_blk   = (mode == MODE_BLK) && (opcode == OP_LDST);

  // One encoder serves both the fresh list (IDLE) and the latched remainder (BLOCK).
  assign sel_list = (state == ST_BLOCK) ? pending : reg_list;
  assign rest     = sel_list & ~(REG_COUNT'(1) << lsb_idx);

  lowest_set_bit #(
    .REG_COUNT (REG_COUNT),
    .IDX_W     (REG_IDX_W)
  ) u_lsb (
    .vec (sel_list),
    .idx (lsb_idx),
    .any (lsb_any)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state         <= ST_IDLE;
      pending       <= '0;
      ord           <= '0;
      blk_load      <= 1'b0;
      valid_out     <= 1'b0;
      exe_cmd       <= '0;
      wb_en         <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      branch        <= 1'b0;
      status_update <= 1'b0;
      uop_reg       <= '0;
      uop_offset    <= '0;
      uop_last      <= 1'b0;
    end else if (!stall) begin
      state         <= state_d;
      pending       <= pending_d;
      ord           <= ord_d;
      blk_load      <= blk_load_d;
      valid_out     <= valid_d;
      exe_cmd       <= exe_d;
      wb_en         <= wb_d;
      mem_read      <= rd_d;
      mem_write     <= wr_d;
      branch        <= br_d;
      status_update <= su_d;
      uop_reg       <= reg_d;
      uop_offset    <= off_d;
      uop_last      <= last_d;
    end
  end

  always_comb begin
    state_d    = state;
    pending_d  = pending;
    ord_d      = ord;
    blk_load_d = blk_load;
    case (state)
      ST_IDLE: begin
        if (accept && is_blk && (rest != '0)) begin
          state_d    = ST_BLOCK;
          pending_d  = rest;
          ord_d      = REG_IDX_W'(1);
          blk_load_d = s_bit;
        end
      end
      ST_BLOCK: begin
        pending_d = rest;
        ord_d     = ord + REG_IDX_W'(1);
        if (rest == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    exe_d   = '0;
    wb_d    = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    br_d    = 1'b0;
    su_d    = 1'b0;
    reg_d   = '0;
    off_d   = '0;
    last_d  = 1'b0;
    if (state == ST_BLOCK) begin
      valid_d = 1'b1;
      exe_d   = EXE_CMD_W'(EXE_ADD);
      wb_d    = blk_load;
      rd_d    = blk_load;
      wr_d    = !blk_load;
      reg_d   = lsb_idx;
      off_d   = OFFSET_W'(ord) << 2;
      last_d  = (rest == '0);
    end else if (accept) begin
      valid_d = 1'b1;
      last_d  = 1'b1;
      case (mode)
        MODE_DP: begin
          case (opcode)
            OP_MOV, OP_MVN, OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_ORR, OP_EOR: begin
              exe_d = EXE_CMD_W'(dp_cmd(opcode));
              wb_d  = 1'b1;
              su_d  = s_bit;
            end
            OP_AND: begin
              exe_d = EXE_CMD_W'(EXE_AND);
              wb_d  = !nop;
              su_d  = s_bit && !nop;
            end
            OP_CMP: begin
              exe_d = EXE_CMD_W'(EXE_SUB);
              su_d  = 1'b1;
            end
            OP_TST: begin
              exe_d = EXE_CMD_W'(EXE_AND);
              su_d  = 1'b1;
            end
            default: ;
          endcase
        end
        MODE_MEM: begin
          if (opcode == OP_LDST) begin
            exe_d = EXE_CMD_W'(EXE_ADD);
            wb_d  = s_bit;
            rd_d  = s_bit;
            wr_d  = !s_bit;
          end
        end
        MODE_BR: br_d = 1'b1;
        MODE_BLK: begin
          if (is_blk && lsb_any) begin
            exe_d  = EXE_CMD_W'(EXE_ADD);
            wb_d   = s_bit;
            rd_d   = s_bit;
            wr_d   = !s_bit;
            reg_d  = lsb_idx;
            last_d = (rest == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Registered successor to the combinational ID-stage control decoder. It decodes mode/opcode/S into execute-stage control signals and drives them through an output register with stall and flush support. It adds block transfer (LDM/STM): one instruction expands into one memory micro-op per set bit of a register list. It sits between the ID stage and the ID/EX register and back-pressures fetch/decode while a block transfer is expanding.

Parameters:
REG_COUNT, 16, number of architectural registers; width of the register list
REG_IDX_W, 4, width of a register index; must equal clog2(REG_COUNT)
OFFSET_W, 6, width of the byte offset of a micro-op; must equal REG_IDX_W+2
EXE_CMD_W, 4, width of the ALU command

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_in  in  1  decoded instruction present
in_ready  out  1  block accepts an instruction this cycle
mode  in  2  instruction class: 0 data-processing, 1 single memory, 2 branch, 3 block transfer
opcode  in  4  operation field
s_bit  in  1  S bit (load/store select for modes 1 and 3)
nop  in  1  instruction is a pipeline bubble
reg_list  in  REG_COUNT  block-transfer register list, bit i = register i
stall  in  1  hold all outputs and state (hazard unit)
flush  in  1  kill the current and pending micro-ops (branch taken)
valid_out  out  1  output bundle valid
exe_cmd  out  EXE_CMD_W  ALU command
wb_en  out  1  register write-back enable
mem_read  out  1  memory load
mem_write  out  1  memory store
branch  out  1  branch instruction
status_update  out  1  update CPSR flags
uop_reg  out  REG_IDX_W  block-transfer target register
uop_offset  out  OFFSET_W  byte offset from the base register (4 x ordinal)
uop_last  out  1  last micro-op of the instruction (1 for non-block ops)

Behaviour:
- Reset (highest priority): every output is 0 except in_ready, which is 1. The state is IDLE and the pending list is cleared.
- Interface as decided: single clock clk; rst is synchronous and active-high.
- Precedence is rst > flush > stall. flush zeroes all outputs, forces the state to IDLE and clears the pending list, all in the same edge.
- in_ready = (state==IDLE) & ~stall. An instruction is accepted when valid_in & in_ready.
- Latency is 1 cycle: the accepted instruction's bundle appears on the registered outputs at the next edge.
- Cycle with no acceptance and no pending micro-op: the next state has valid_out=0 and all enables 0.
- While stall=1, all outputs and the FSM hold their values.
- Mode 0 decode (opcode -> exe_cmd, wb_en, status_update):
  - 1101->0001, 1111->1001, 0100->0010, 0101->0011, 0010->0100, 0110->0101, 1100->0111, 0001->1000: wb_en=1, status_update=s_bit.
  - 0000->0110: wb_en=~nop, status_update=s_bit&~nop.
  - 1010 (CMP)->0100 and 1000 (TST)->0110: wb_en=0, status_update=1.
  - Any other opcode: all outputs 0, valid_out=1.
- Mode 1, opcode 0100: exe_cmd=0010, wb_en=mem_read=s_bit, mem_write=~s_bit. Any other opcode decodes as all-zero.
- Mode 2: branch=1; all other controls 0.
- Mode 3, opcode 0100 is a block transfer:
  - Micro-ops are issued in ascending register index.
  - Each micro-op has exe_cmd=0010, mem_read=wb_en=s_bit, mem_write=~s_bit, uop_reg=index, uop_offset=4*ordinal. The ordinal starts at 0.
  - Offset arithmetic is modulo 2^OFFSET_W; no overflow is possible at legal widths.
- FSM states: IDLE, BLOCK.
  - IDLE->BLOCK on accepting a block transfer whose list has 2 or more bits set. The first micro-op is emitted at that edge and the remaining list is latched.
  - In BLOCK, each non-stalled cycle emits the lowest remaining bit and clears it.
  - The micro-op that empties the list sets uop_last=1 and returns the FSM to IDLE. in_ready rises combinationally in that cycle.
- Single-bit list: one micro-op with uop_last=1; the FSM stays in IDLE.
- Empty list: one bundle with valid_out=1, all enables 0 and uop_last=1 (architectural NOP).
- Inputs (mode, opcode, s_bit, reg_list) are sampled only on acceptance. Changes during BLOCK are ignored.
- Simultaneous flush and valid_in: nothing is accepted.
- Reset during BLOCK: the remaining micro-ops are discarded and no further micro-op is emitted.

Decomposition:
- Package ctrl_pkg holds:
  - mode constants: MODE_DP, MODE_MEM, MODE_BR, MODE_BLK
  - opcode constants: OP_MOV, OP_MVN, OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_ORR, OP_EOR, OP_CMP, OP_TST, OP_LDST
  - exe_cmd codes
  - the FSM state enum
- One sub-module, lowest_set_bit (parametrised by REG_COUNT). It outputs the index of the lowest set bit plus an any-set flag. It is used for micro-op selection.

Test Plan:
1. Mode 0, opcode 0100, s_bit=1 accepted at cycle 0 -> cycle 1: valid_out=1, exe_cmd=0010, wb_en=1, status_update=1, uop_last=1.
2. Mode 0, opcode 0000, nop=1 -> exe_cmd=0110, wb_en=0, status_update=0. Opcode 1010 -> exe_cmd=0100, wb_en=0, status_update=1.
3. Mode 3 LDM (s_bit=1), reg_list=0x8025 -> four micro-ops:
   - uop_reg 0, 2, 5, 15 with uop_offset 0, 4, 8, 12; mem_read=wb_en=1.
   - uop_last only on reg 15.
   - in_ready=0 through the first three micro-ops.
4. STM with reg_list=0x0006 and stall=1 asserted during the second micro-op for 3 cycles -> outputs hold reg 1, offset 0 for 3 cycles; then reg 2, offset 4, mem_write=1, uop_last=1.
5. LDM with reg_list=0x00F0 and flush at the second micro-op -> the next cycle has valid_out=0 and all enables 0, in_ready=1, and regs 6–7 are never emitted.
6. Mode 3 with reg_list=0 -> a single bundle with valid_out=1, uop_last=1 and all enables 0. rst asserted during BLOCK -> all outputs 0 at the next edge and in_ready=1.
